// File: rtl/exec_ctrl_if.sv
// Bus between the execute-stage controller, its instruction source and the ALU.
// Handshake: an instruction transfers on a rising edge where in_valid & in_ready; once in_valid is raised, in_instr stays stable until that edge.
interface exec_ctrl_if;
  logic        in_valid;
  logic [12:0] in_instr;
  logic        in_ready;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic [7:0]  alu_result;
  logic        alu_cf;
  logic        alu_ovf;
  logic        alu_z;
  logic        alu_neg;
  logic [3:0]  flags;
  logic        done;
  logic [2:0]  dbg_addr;
  logic [7:0]  dbg_data;
  logic        fsm_state;

  modport master (
    output in_valid, in_instr, alu_result, alu_cf, alu_ovf, alu_z, alu_neg, dbg_addr,
    input  in_ready, alu_a, alu_b, alu_op, flags, done, dbg_data, fsm_state
  );

  modport slave (
    input  in_valid, in_instr, alu_result, alu_cf, alu_ovf, alu_z, alu_neg, dbg_addr,
    output in_ready, alu_a, alu_b, alu_op, flags, done, dbg_data, fsm_state
  );
endinterface

// File: rtl/exec_ctrl.sv
// Execute-stage controller: 8x8 register file, local load-immediate, and ALU
// dispatch with write-back after ALU_LAT+1 wait edges.
module exec_ctrl #(
  parameter int ALU_LAT = 1
) (
  input logic        clk,
  input logic        areset,
  exec_ctrl_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t     state;
  logic [7:0] rf [8];
  logic [2:0] cnt;
  logic [2:0] rd_q;
  logic       ready_q;
  logic       done_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [2:0] op_q;
  logic [3:0] flags_q;

  logic       is_load;
  logic [2:0] op_f;
  logic [2:0] rd_f;
  logic [2:0] rs1_f;
  logic [2:0] rs2_f;
  logic [2:0] ld_rd;
  logic [7:0] imm;

  assign is_load = bus.in_instr[12];
  assign op_f    = bus.in_instr[11:9];
  assign rd_f    = bus.in_instr[8:6];
  assign rs1_f   = bus.in_instr[5:3];
  assign rs2_f   = bus.in_instr[2:0];
  assign ld_rd   = bus.in_instr[11:9];
  assign imm     = bus.in_instr[7:0];

  // Operands are captured at accept, so a later write-back to rd never
  // disturbs the values the ALU is working on.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state   <= IDLE;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
      cnt     <= '0;
      rd_q    <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      flags_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (is_load) begin
              rf[ld_rd] <= imm;
              done_q    <= 1'b1;
            end else begin
              a_q     <= rf[rs1_f];
              b_q     <= rf[rs2_f];
              op_q    <= op_f;
              rd_q    <= rd_f;
              cnt     <= 3'(ALU_LAT);
              ready_q <= 1'b0;
              state   <= EXEC;
            end
          end
        end
        EXEC: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            rf[rd_q] <= bus.alu_result;
            flags_q  <= {bus.alu_cf, bus.alu_ovf, bus.alu_z, bus.alu_neg};
            done_q   <= 1'b1;
            ready_q  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.done      = done_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_op    = op_q;
  assign bus.flags     = flags_q;
  assign bus.dbg_data  = rf[bus.dbg_addr];
  assign bus.fsm_state = state;
endmodule
